// File: rtl/bl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bl_pkg
// Purpose  : shared sizes, timing defaults and FSM encoding for bl_frame_sched
// Revision : 1.0
// ============================================================================
package bl_pkg;

    localparam int BL_NUM_LED      = 360;
    localparam int BL_AW           = 10;
    localparam int BL_DW           = 16;
    localparam int BL_CFG_WAIT     = 2500;
    localparam int BL_FRAME_PERIOD = 420000;
    localparam int BL_PULSE_LEN    = 29;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2
    } bl_state_t;

endpackage
`default_nettype wire

// File: rtl/bl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : bl_frame_timer
// Purpose  : post-reset config wait, frame period counter / tick, sdbpflag pulse
// Revision : 1.0
// ============================================================================
module bl_frame_timer
    import bl_pkg::*;
#(
    parameter int CFG_WAIT     = BL_CFG_WAIT,
    parameter int FRAME_PERIOD = BL_FRAME_PERIOD,
    parameter int PULSE_LEN    = BL_PULSE_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in_wait,
    input  logic i_in_idle,
    output logic o_cfg_done,
    output logic o_tick,
    output logic o_sdbpflag
);

    localparam int c_cw = (CFG_WAIT > 1) ? $clog2(CFG_WAIT) : 1;
    localparam int c_pw = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int c_lw = (PULSE_LEN > 1) ? $clog2(PULSE_LEN + 1) : 1;

    localparam logic [c_cw-1:0] c_cfg_last   = c_cw'(CFG_WAIT - 1);
    localparam logic [c_pw-1:0] c_per_last   = c_pw'(FRAME_PERIOD - 1);
    localparam logic [c_lw-1:0] c_pulse_last = c_lw'(PULSE_LEN - 1);

    logic [c_cw-1:0] r_cfg_cnt;
    logic [c_pw-1:0] r_per_cnt;
    logic [c_lw-1:0] r_pulse_cnt;
    logic            r_sdbpflag;

    assign o_cfg_done = i_in_wait && (r_cfg_cnt == c_cfg_last);
    assign o_tick     = i_in_idle && (r_per_cnt == '0);
    assign o_sdbpflag = r_sdbpflag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_cnt   <= '0;
            r_per_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_sdbpflag  <= 1'b0;
        end else begin
            if (i_in_wait && !o_cfg_done) begin
                r_cfg_cnt <= r_cfg_cnt + c_cw'(1);
            end

            // Period keeps counting through FILL so frames stay evenly spaced.
            if (i_in_wait) begin
                r_per_cnt <= '0;
            end else if (r_per_cnt == c_per_last) begin
                r_per_cnt <= '0;
            end else begin
                r_per_cnt <= r_per_cnt + c_pw'(1);
            end

            if (o_tick) begin
                r_sdbpflag  <= 1'b1;
                r_pulse_cnt <= c_pulse_last;
            end else if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - c_lw'(1);
            end else begin
                r_sdbpflag  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bl_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : bl_frame_sched
// Purpose  : frame pacing, per-frame buffer refill and host write arbitration.
//            Host write port enabled by BL_HOST_PORT_EN.
// Revision : 1.0
// ============================================================================
module bl_frame_sched
    import bl_pkg::*;
#(
    parameter int NUM_LED      = BL_NUM_LED,
    parameter int AW           = BL_AW,
    parameter int DW           = BL_DW,
    parameter int CFG_WAIT     = BL_CFG_WAIT,
    parameter int FRAME_PERIOD = BL_FRAME_PERIOD,
    parameter int PULSE_LEN    = BL_PULSE_LEN
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pat_rd_en,
    output logic [AW-1:0] pat_rd_addr,
    input  logic [DW-1:0] pat_rd_data,
    input  logic          host_valid,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic          host_ready,
    output logic          wt_we,
    output logic [AW-1:0] wt_addr,
    output logic [DW-1:0] wt_din,
    output logic          sdbpflag,
    output logic          frame_done,
    output logic          addr_err
);

    generate
        if (FRAME_PERIOD <= NUM_LED + PULSE_LEN + 2) begin : g_bad_period
            $error("bl_frame_sched: FRAME_PERIOD must exceed NUM_LED + PULSE_LEN + 2");
        end
    endgenerate

    localparam logic [AW-1:0] c_last_addr = AW'(NUM_LED - 1);

    bl_state_t     r_state;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr;
    logic          r_wt_we;
    logic [AW-1:0] r_wt_addr;
    logic          r_fill_wr;
    logic [DW-1:0] r_host_data;
    logic          r_frame_done;
    logic          r_addr_err;

    logic w_tick;
    logic w_cfg_done;
    logic w_host_ready;
    logic w_host_acc;
    logic w_host_in_range;

    bl_frame_timer #(
        .CFG_WAIT     (CFG_WAIT),
        .FRAME_PERIOD (FRAME_PERIOD),
        .PULSE_LEN    (PULSE_LEN)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_in_wait  (r_state == ST_WAIT),
        .i_in_idle  (r_state == ST_IDLE),
        .o_cfg_done (w_cfg_done),
        .o_tick     (w_tick),
        .o_sdbpflag (sdbpflag)
    );

`ifdef BL_HOST_PORT_EN
    assign w_host_ready    = (r_state == ST_IDLE) && !w_tick;
    assign w_host_acc      = host_valid && w_host_ready;
    assign w_host_in_range = ({1'b0, host_addr} < (AW+1)'(NUM_LED));
`else
    logic w_unused_host;
    assign w_unused_host   = ^{host_valid, host_addr, host_data};
    assign w_host_ready    = 1'b0;
    assign w_host_acc      = 1'b0;
    assign w_host_in_range = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_WAIT;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_wt_we      <= 1'b0;
            r_wt_addr    <= '0;
            r_fill_wr    <= 1'b0;
            r_host_data  <= '0;
            r_frame_done <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_wt_we      <= 1'b0;
            r_fill_wr    <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                ST_WAIT: begin
                    if (w_cfg_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state   <= ST_FILL;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                ST_FILL: begin
                    // Each read address is written back one cycle later with the returned word.
                    if (r_rd_en) begin
                        r_wt_we   <= 1'b1;
                        r_wt_addr <= r_rd_addr;
                        r_fill_wr <= 1'b1;
                        if (r_rd_addr == c_last_addr) begin
                            r_rd_en      <= 1'b0;
                            r_rd_addr    <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + AW'(1);
                        end
                    end
                    if (r_frame_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_WAIT;
            endcase

            // Host is only ever granted in IDLE, so it never overlaps a fill write.
            if (w_host_acc) begin
                r_wt_we     <= w_host_in_range;
                r_wt_addr   <= host_addr;
                r_host_data <= host_data;
                if (!w_host_in_range) begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    // Pattern RAM output is already registered, so fill data is forwarded straight through.
    assign wt_din      = r_fill_wr ? pat_rd_data : r_host_data;
    assign wt_we       = r_wt_we;
    assign wt_addr     = r_wt_addr;
    assign pat_rd_en   = r_rd_en;
    assign pat_rd_addr = r_rd_addr;
    assign frame_done  = r_frame_done;
    assign addr_err    = r_addr_err;
    assign host_ready  = w_host_ready;

endmodule
`default_nettype wire

// File: tb/tb_bl_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bl_frame_sched
// Purpose  : randomized self-checking bench for bl_frame_sched vs. a timing-formula model
// Revision : 1.0
// ============================================================================
module tb_bl_frame_sched;

    localparam int NUM_LED   = 360;
    localparam int AW        = 10;
    localparam int DW        = 16;
    localparam int CFG_WAIT  = 2500;
    localparam int FP        = 1000;
    localparam int PULSE_LEN = 29;
`ifdef BL_HOST_PORT_EN
    localparam bit HOST_EN = 1'b1;
`else
    localparam bit HOST_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pat_rd_en;
    logic [AW-1:0] pat_rd_addr;
    logic [DW-1:0] pat_rd_data;
    logic          host_valid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          host_ready;
    logic          wt_we;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_din;
    logic          sdbpflag;
    logic          frame_done;
    logic          addr_err;

    bl_frame_sched #(
        .NUM_LED      (NUM_LED),
        .AW           (AW),
        .DW           (DW),
        .CFG_WAIT     (CFG_WAIT),
        .FRAME_PERIOD (FP),
        .PULSE_LEN    (PULSE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pat_rd_en   (pat_rd_en),
        .pat_rd_addr (pat_rd_addr),
        .pat_rd_data (pat_rd_data),
        .host_valid  (host_valid),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .wt_we       (wt_we),
        .wt_addr     (wt_addr),
        .wt_din      (wt_din),
        .sdbpflag    (sdbpflag),
        .frame_done  (frame_done),
        .addr_err    (addr_err)
    );

    always #20 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int unsigned   edge_cnt = 0;
    int unsigned   last_rst = 0;
    bit            hw_pend  = 1'b0;
    logic [AW-1:0] hw_addr;
    logic [DW-1:0] hw_data;
    bit            m_addr_err = 1'b0;
    bit            acc_last   = 1'b0;
    logic [DW-1:0] mem [0:1023];
    int            cnt_we = 0;
    int            cnt_fd = 0;
    int            rise_e[$];
    bit            prev_sdbp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Cycles since the first tick; negative while still in the post-reset wait.
    function automatic int cur_o();
        return int'(edge_cnt - last_rst) - CFG_WAIT;
    endfunction

    function automatic bit exp_ready(input int o);
        return HOST_EN && (o >= 0) && ((o % FP) > NUM_LED + 1);
    endfunction

    // Model state update and pattern RAM (data valid the cycle after the read strobe).
    always @(posedge clk) begin
        int o;
        o        = cur_o();
        acc_last = 1'b0;
        hw_pend  = 1'b0;
        if (rst) begin
            last_rst   = edge_cnt + 1;
            m_addr_err = 1'b0;
        end else if (host_valid && exp_ready(o)) begin
            acc_last = 1'b1;
            hw_pend  = 1'b1;
            hw_addr  = host_addr;
            hw_data  = host_data;
            if (host_addr >= NUM_LED) m_addr_err = 1'b1;
        end
        edge_cnt++;
        if (pat_rd_en) pat_rd_data <= mem[pat_rd_addr];
    end

    always @(negedge clk) begin
        int            o;
        int            ph;
        logic          e_sdbp, e_en, e_we, e_fd, e_rdy;
        logic [AW-1:0] e_raddr, e_waddr;
        logic [DW-1:0] e_din;
        o = cur_o();
        e_sdbp = 1'b0; e_en = 1'b0; e_we = 1'b0; e_fd = 1'b0; e_rdy = 1'b0;
        e_raddr = '0; e_waddr = '0; e_din = '0;
        if (o >= 0) begin
            ph     = o % FP;
            e_sdbp = (ph >= 1) && (ph <= PULSE_LEN);
            e_en   = (ph >= 1) && (ph <= NUM_LED);
            if (e_en) e_raddr = AW'(ph - 1);
            if ((ph >= 2) && (ph <= NUM_LED + 1)) begin
                e_we    = 1'b1;
                e_waddr = AW'(ph - 2);
                e_din   = mem[ph - 2];
            end
            e_fd  = (ph == NUM_LED + 1);
            e_rdy = exp_ready(o);
        end
        if (hw_pend && (hw_addr < NUM_LED)) begin
            e_we    = 1'b1;
            e_waddr = hw_addr;
            e_din   = hw_data;
        end
        check("sdbpflag", sdbpflag, e_sdbp);
        check("pat_rd_en", pat_rd_en, e_en);
        check("wt_we", wt_we, e_we);
        check("frame_done", frame_done, e_fd);
        check("host_ready", host_ready, e_rdy);
        check("addr_err", addr_err, m_addr_err);
        if (o < 0) begin
            check("idle_rd_addr", pat_rd_addr, 0);
            check("idle_wt_addr", wt_addr, 0);
            check("idle_wt_din", wt_din, 0);
        end else begin
            if (e_en) check("pat_rd_addr", pat_rd_addr, e_raddr);
            if (e_we) begin
                check("wt_addr", wt_addr, e_waddr);
                check("wt_din", wt_din, e_din);
            end
        end
        cnt_we += int'(wt_we);
        cnt_fd += int'(frame_done);
        if (sdbpflag && !prev_sdbp) rise_e.push_back(int'(edge_cnt - last_rst));
        prev_sdbp = sdbpflag;
    end

    task automatic wait_ph(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((cur_o() >= 0) && ((cur_o() % FP) == target)) && (n < CFG_WAIT + 4 * FP));
        if (n >= CFG_WAIT + 4 * FP) check("wait_ph_timeout", cur_o() % FP, target);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i * 3);
        rst        = 1'b1;
        host_valid = 1'b0;
        host_addr  = '0;
        host_data  = '0;
        repeat (4) @(negedge clk);
        rst    = 1'b0;
        cnt_we = 0;
        cnt_fd = 0;
        rise_e.delete();

        // Three undisturbed frames
        repeat (CFG_WAIT + 3 * FP - 1) @(negedge clk);
        check("a_we_count", cnt_we, 3 * NUM_LED);
        check("a_fd_count", cnt_fd, 3);
        check("a_ticks", rise_e.size(), 3);
        if (rise_e.size() >= 1) check("a_first_rise", rise_e[0], CFG_WAIT + 1);
        for (int i = 1; i < rise_e.size(); i++) check("a_tick_gap", rise_e[i] - rise_e[i-1], FP);

`ifdef BL_HOST_PORT_EN
        // Request raised on the tick cycle must wait out the whole fill
        wait_ph(0);
        check("c_ready_at_tick", host_ready, 0);
        host_valid = 1'b1;
        host_addr  = AW'($urandom_range(0, NUM_LED - 1));
        host_data  = DW'($urandom);
        n = 0;
        while (!host_ready && n < 2 * FP) begin
            @(negedge clk);
            n++;
        end
        check("c_ready_phase", cur_o() % FP, NUM_LED + 2);
        @(negedge clk);
        host_valid = 1'b0;
        check("c_host_we", wt_we, 1);
        check("c_host_addr", wt_addr, host_addr);
        check("c_host_data", wt_din, host_data);

        // Out-of-range write in IDLE
        wait_ph(500);
        check("d_err_before", addr_err, 0);
        host_valid = 1'b1;
        host_addr  = AW'(NUM_LED);
        host_data  = DW'($urandom);
        @(negedge clk);
        host_valid = 1'b0;
        check("d_err_set", addr_err, 1);
        check("d_we_blocked", wt_we, 0);
        repeat (FP) @(negedge clk);
        check("d_err_sticky", addr_err, 1);
`endif

        // Random host traffic; a pending request is held until accepted
        for (int k = 0; k < 3 * FP; k++) begin
            @(negedge clk);
            if (!host_valid || acc_last || !HOST_EN) begin
                host_valid = ($urandom_range(0, 3) == 0);
                host_addr  = AW'($urandom_range(0, NUM_LED + 23));
                host_data  = DW'($urandom);
            end
        end
        host_valid = 1'b0;

        // Reset in the middle of a fill
        wait_ph(101);
        check("e_rd_addr", pat_rd_addr, 100);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!sdbpflag && n < CFG_WAIT + FP) begin
            @(negedge clk);
            n++;
        end
        check("e_first_rise", int'(edge_cnt - last_rst), CFG_WAIT + 1);
        check("e_err_cleared", addr_err, 0);
        repeat (NUM_LED + 10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
